// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, mode encoding and helpers for the multi-channel PWM block
// Contents:
//   PWM_DEFAULT_CHANNELS / PWM_DEFAULT_WIDTH - default top-level parameters
//   pwm_mode_e                               - PWM_MODE_EDGE / PWM_MODE_CENTER encoding
//   sel_width()                              - channel-select width, never below 1 bit
package pwm_pkg;

    localparam int PWM_DEFAULT_CHANNELS = 4;
    localparam int PWM_DEFAULT_WIDTH    = 8;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// pwm_channel_cmp: one PWM channel - shadow duty, active duty and registered comparator
// Ports:
//   SLK, rst  - clock, asynchronous active-high reset
//   enable    - low forces the output low
//   wr/wr_val - duty write strobe and value into the shadow register
//   load      - copy the shadow (including a same-cycle write) into the active register
//   cnt       - shared counter value
//   pwm       - registered output, high while active duty > cnt
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
    input  logic             SLK,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_val,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    // A write landing on a load edge goes straight through to the active register.
    always_comb begin
        shadow_d = wr ? wr_val : shadow_q;
        active_d = load ? shadow_d : active_q;
        pwm_d    = enable && (active_q > cnt);
    end

    always_ff @(posedge SLK or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-counter PWM generator with double-buffered period and per-channel duty
// Ports:
//   SLK, rst   - clock, asynchronous active-high reset
//   enable     - high runs the counter, low idles with outputs low and registers reloading
//   period     - counter top value, taken at each wrap
//   duty_wr    - duty write strobe; duty_sel picks the channel, duty_val the value
//   pwm        - registered channel outputs
//   period_end - registered one-cycle pulse after each wrap
// Define PWM_CENTER_ALIGNED_EN for up/down (triangle) counting; the default build is edge-aligned.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = PWM_DEFAULT_CHANNELS,
    parameter int WIDTH    = PWM_DEFAULT_WIDTH
) (
    input  logic                           SLK,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [WIDTH-1:0]               period,
    input  logic                           duty_wr,
    input  logic [sel_width(CHANNELS)-1:0] duty_sel,
    input  logic [WIDTH-1:0]               duty_val,
    output logic [CHANNELS-1:0]            pwm,
    output logic                           period_end
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_active_q, period_active_d;
    logic             period_end_q, period_end_d;
    logic             wrap, load, sel_ok;

    assign sel_ok = int'(duty_sel) < CHANNELS;

`ifdef PWM_CENTER_ALIGNED_EN
    // dir_q high = counting down. The wrap is the cnt=0 point reached on the way down;
    // a zero period degenerates to a wrap every cycle.
    logic dir_q, dir_d, turn;

    always_comb begin
        wrap  = enable && (cnt_q == '0) && (dir_q || (period_active_q == '0));
        turn  = enable && !dir_q && (cnt_q == period_active_q) && (period_active_q != '0);
        dir_d = enable && !wrap && (dir_q || turn);
        cnt_d = !enable          ? '0 :
                wrap             ? WIDTH'(period != '0) :
                (dir_q || turn)  ? cnt_q - 1'b1 :
                                   cnt_q + 1'b1;
    end

    always_ff @(posedge SLK or posedge rst) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end
`else
    always_comb begin
        wrap  = enable && (cnt_q == period_active_q);
        cnt_d = (!enable || wrap) ? '0 : cnt_q + 1'b1;
    end
`endif

    // While idle the active registers track their sources every cycle, so the
    // first enabled period already uses the latest values.
    always_comb begin
        load            = !enable || wrap;
        period_active_d = load ? period : period_active_q;
        period_end_d    = wrap;
    end

    always_ff @(posedge SLK or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            period_active_q <= '0;
            period_end_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            period_active_q <= period_active_d;
            period_end_q    <= period_end_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_ch (
            .SLK    (SLK),
            .rst    (rst),
            .enable (enable),
            .wr     (duty_wr && sel_ok && (duty_sel == SEL_W'(i))),
            .wr_val (duty_val),
            .load   (load),
            .cnt    (cnt_q),
            .pwm    (pwm[i])
        );
    end

    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: randomized and directed checks of pwm_multi_channel against a period-position model
module tb_pwm_multi_channel;

    localparam int CH = 5;
    localparam int W  = 8;
    localparam int SW = 3;
`ifdef PWM_CENTER_ALIGNED_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif

    logic          SLK = 1'b0;
    logic          rst;
    logic          enable = 1'b0;
    logic [W-1:0]  period = '0;
    logic          duty_wr = 1'b0;
    logic [SW-1:0] duty_sel = '0;
    logic [W-1:0]  duty_val = '0;
    logic [CH-1:0] pwm;
    logic          period_end;

    int passed = 0;
    int total  = 0;

    // Model: position inside the current period, the period/duty values in force,
    // and the values written but not yet in force.
    int            m_pos;
    int            m_pa;
    int            m_sh[CH];
    int            m_act[CH];
    logic [CH-1:0] m_pwm;
    logic          m_pe;

    pwm_multi_channel #(
        .CHANNELS(CH),
        .WIDTH(W)
    ) dut (
        .SLK        (SLK),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .duty_wr    (duty_wr),
        .duty_sel   (duty_sel),
        .duty_val   (duty_val),
        .pwm        (pwm),
        .period_end (period_end)
    );

    always #5 SLK = ~SLK;

    // Counter value seen at a given position: a ramp, or a triangle when centre-aligned.
    function automatic int cnt_of(input int pos, input int pa);
        return (!CENTER || pos <= pa) ? pos : 2 * pa - pos;
    endfunction

    function automatic bit at_end(input int pos, input int pa);
        return CENTER ? (pos == 2 * pa) : (pos == pa);
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_pa  = 0;
        m_pwm = '0;
        m_pe  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
    endtask

    task automatic tick();
        int c;
        bit w;
        @(posedge SLK);
        c = cnt_of(m_pos, m_pa);
        w = enable && at_end(m_pos, m_pa);
        for (int i = 0; i < CH; i++) m_pwm[i] = enable && (m_act[i] > c);
        m_pe = w;
        if (duty_wr && int'(duty_sel) < CH) m_sh[duty_sel] = int'(duty_val);
        if (!enable || w) begin
            m_pa = int'(period);
            for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
        end
        m_pos = !enable ? 0 : w ? ((CENTER && m_pa != 0) ? 1 : 0) : m_pos + 1;
        @(negedge SLK);
    endtask

    task automatic write(input int sel, input int val);
        duty_wr  = 1'b1;
        duty_sel = SW'(sel);
        duty_val = W'(val);
        tick();
        duty_wr  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (pwm !== '0) $display("FAIL reset_pwm: pwm=%b expected %b", pwm, {CH{1'b0}}); else passed++;
        total++; if (period_end !== 1'b0) $display("FAIL reset_pe: period_end=%b expected 0", period_end); else passed++;
        @(negedge SLK);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL reset_idle cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
        period = W'(5);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL reset_run cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
    endtask

    task automatic test_basic();
        int hi = 0;
        int pe = 0;
        enable = 1'b0;
        period = W'(9);
        write(0, 4);
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL basic cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
            hi += int'(pwm[0]);
            pe += int'(period_end);
        end
        total++; if (hi != 16) $display("FAIL basic_high_count: got %0d expected 16", hi); else passed++;
        total++; if (pe != 4) $display("FAIL basic_pe_count: got %0d expected 4", pe); else passed++;
    endtask

    task automatic test_duty_update();
        int h1 = 0;
        int h2 = 0;
        enable = 1'b0;
        period = W'(9);
        write(1, 2);
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                duty_wr  = 1'b1;
                duty_sel = SW'(1);
                duty_val = W'(7);
            end
            tick();
            duty_wr = 1'b0;
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL duty_update cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
            if (k <= 10) h1 += int'(pwm[1]);
            else h2 += int'(pwm[1]);
        end
        total++; if (h1 != 2) $display("FAIL duty_update_cur: got %0d expected 2", h1); else passed++;
        total++; if (h2 != 7) $display("FAIL duty_update_next: got %0d expected 7", h2); else passed++;
    endtask

    task automatic test_extremes();
        int hi0 = 0;
        int hi1 = 0;
        enable = 1'b0;
        period = W'(99);
        write(0, 0);
        write(1, 200);
        enable = 1'b1;
        for (int k = 0; k < 210; k++) begin
            tick();
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
            if (k % 10 == 0) begin
                total++;
                if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL extremes cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
                else passed++;
            end
        end
        total++; if (hi0 != 0) $display("FAIL extremes_zero: high cycles %0d expected 0", hi0); else passed++;
        total++; if (hi1 != 210) $display("FAIL extremes_full: high cycles %0d expected 210", hi1); else passed++;
    endtask

    task automatic test_period_zero();
        int bad = 0;
        enable = 1'b0;
        period = '0;
        for (int i = 0; i < CH; i++) write(i, 1);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pwm !== {CH{1'b1}} || period_end !== 1'b1) bad++;
        end
        total++; if (bad != 0) $display("FAIL period_zero: %0d cycles off, expected pwm=%b pe=1", bad, {CH{1'b1}}); else passed++;
        for (int s = CH; s < 8; s++) write(s, 0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pwm !== {CH{1'b1}} || period_end !== 1'b1) bad++;
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL bad_sel cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
        total++; if (bad != 0) $display("FAIL bad_sel_ignored: %0d cycles off, expected pwm=%b", bad, {CH{1'b1}}); else passed++;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        int nz = 0;
        enable = 1'b0;
        period = W'(9);
        write(0, 4);
        write(2, 9);
        enable = 1'b1;
        while (m_pos != 5 && guard < 30) begin
            tick();
            guard++;
        end
        total++; if (m_pos != 5) $display("FAIL async_reach_cnt5: position %0d expected 5", m_pos); else passed++;
        total++; if (pwm[2] !== 1'b1) $display("FAIL async_pre_high: pwm[2]=%b expected 1", pwm[2]); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (pwm !== '0 || period_end !== 1'b0) $display("FAIL async_clear: pwm=%b pe=%b expected 0 0", pwm, period_end); else passed++;
        model_reset();
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (pwm !== '0) nz++;
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL async_restart cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
        total++; if (nz != 0) $display("FAIL async_duties_cleared: %0d cycles with pwm high, expected 0", nz); else passed++;
        write(0, 3);
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL async_rewrite cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(19) == 0) enable = ~enable;
            if ($urandom_range(7) == 0) period = W'($urandom_range(12));
            duty_wr  = ($urandom_range(2) == 0);
            duty_sel = SW'($urandom_range(7));
            duty_val = W'($urandom_range(15));
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL random cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
        end
        duty_wr = 1'b0;
    endtask

`ifdef PWM_CENTER_ALIGNED_EN
    task automatic test_center();
        int   guard = 0;
        int   hi = 0;
        logic p[8];
        enable = 1'b0;
        period = W'(4);
        write(0, 2);
        enable = 1'b1;
        do begin
            tick();
            guard++;
        end while (period_end !== 1'b1 && guard < 20);
        total++; if (period_end !== 1'b1) $display("FAIL center_first_pe: period_end=%b expected 1", period_end); else passed++;
        p[0] = pwm[0];
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (pwm !== m_pwm || period_end !== m_pe) $display("FAIL center cyc%0d: pwm=%b pe=%b expected pwm=%b pe=%b", k, pwm, period_end, m_pwm, m_pe);
            else passed++;
            if (k < 8) begin
                p[k] = pwm[0];
                total++; if (period_end !== 1'b0) $display("FAIL center_pe_gap cyc%0d: period_end=%b expected 0", k, period_end); else passed++;
            end else begin
                total++; if (period_end !== 1'b1) $display("FAIL center_pe_period: period_end=%b expected 1", period_end); else passed++;
            end
        end
        for (int k = 0; k < 8; k++) hi += int'(p[k]);
        total++; if (hi != 3) $display("FAIL center_high_count: got %0d expected 3", hi); else passed++;
        total++; if (p[0] !== 1'b1) $display("FAIL center_mid_high: got %b expected 1", p[0]); else passed++;
        for (int k = 1; k < 4; k++) begin
            total++;
            if (p[k] !== p[8-k]) $display("FAIL center_symmetry k%0d: got %b expected %b", k, p[k], p[8-k]);
            else passed++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
`ifndef PWM_CENTER_ALIGNED_EN
        test_basic();
        test_duty_update();
`else
        test_center();
`endif
        test_extremes();
        test_period_zero();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
